arith_unit_seq: RTL and testbench

//  Parametrised sequential arithmetic unit for the calculator datapath: signed ADD, SUB and MUL on N-bit two's-complement operands.

---
 rtl/arith_unit_seq.sv | 121 ++++++++++++
 tb/tb_arith_unit_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// Sequential signed ADD/SUB/MUL unit with valid/ready on both sides.
// Add/sub resolve on the accept edge; multiply runs N shift-add iterations on magnitudes.
module arith_unit_seq #(
  parameter int N   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic         OVR
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MAX_P = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic           sign;

  // Handshake flags are gated by reset so they read low while reset is held
  // and come up in the very first cycle after it is released.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !reset;

  logic         sub;
  logic [N-1:0] b_op;
  logic [N:0]   sum;
  logic         as_ovf;
  logic [N-1:0] as_res;

  assign sub    = op[0];
  assign b_op   = sub ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, sub};
  // carry into the MSB recovered from the MSB sum bit and its two inputs
  assign as_ovf = (A[N-1] ^ b_op[N-1] ^ sum[N-1]) ^ sum[N];
  assign as_res = (SAT && as_ovf) ? (A[N-1] ? MIN_N : MAX_P) : sum[N-1:0];

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] prod;
  logic           mul_ovf;
  logic [N-1:0]   mul_res;

  assign mag_a    = A[N-1] ? -A : A;
  assign mag_b    = B[N-1] ? -B : B;
  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign prod     = sign ? -acc_next : acc_next;
  assign mul_ovf  = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
  assign mul_res  = (SAT && mul_ovf) ? (sign ? MIN_N : MAX_P) : prod[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      Result <= '0;
      OVR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (op)
              2'b00, 2'b01: begin
                Result <= as_res;
                OVR    <= as_ovf;
                state  <= DONE;
              end
              2'b10: begin
                mplier <= mag_b;
                mcand  <= {{N{1'b0}}, mag_a};
                acc    <= '0;
                sign   <= A[N-1] ^ B[N-1];
                count  <= CW'(N);
                state  <= MUL;
              end
              default: begin
                Result <= '0;
                OVR    <= 1'b1;
                state  <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= {mcand[2*N-2:0], 1'b0};
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          // last iteration folds straight into the result so out_valid lands N+1 cycles after accept
          if (count == CW'(1)) begin
            Result <= mul_res;
            OVR    <= mul_ovf;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Randomized bench for arith_unit_seq: three instances (N=8 wrap, N=8 saturate, N=16 wrap)
// driven together and compared against an integer reference model.
module tb_arith_unit_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [1:0]  op;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, o0, o1, o2;
  logic [7:0]  r0, r1;
  logic [15:0] r2;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_r [3];
  logic        last_o [3];

  always #5 clk = ~clk;

  arith_unit_seq #(.N(8), .SAT(1'b0)) u_wrap8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .op(op),
    .A(a8), .B(b8), .out_valid(vld0), .out_ready(out_ready), .Result(r0), .OVR(o0));

  arith_unit_seq #(.N(8), .SAT(1'b1)) u_sat8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .A(a8), .B(b8), .out_valid(vld1), .out_ready(out_ready), .Result(r1), .OVR(o1));

  arith_unit_seq #(.N(16), .SAT(1'b0)) u_wrap16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .op(op),
    .A(a16), .B(b16), .out_valid(vld2), .out_ready(out_ready), .Result(r2), .OVR(o2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_model(input int n, input bit sat, input logic [1:0] o,
                                    input longint a, input longint b,
                                    output logic [31:0] res, output bit ovr);
    longint t, mx, mn, mask;
    mx   = (longint'(1) << (n - 1)) - 1;
    mn   = -(longint'(1) << (n - 1));
    mask = (longint'(1) << n) - 1;
    case (o)
      2'b00: t = a + b;
      2'b01: t = a - b;
      2'b10: t = a * b;
      default: begin
        res = 32'h0;
        ovr = 1'b1;
        return;
      end
    endcase
    ovr = (t > mx) || (t < mn);
    if (sat && ovr) t = (t > 0) ? mx : mn;
    res = 32'(t & mask);
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_txn(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] c, input logic [15:0] d, input int hold);
    logic [31:0] er [3];
    bit          eo [3];
    int          lat [3];
    int          exp_lat [3];
    logic [2:0]  v;
    ref_model(8,  1'b0, o, longint'($signed(a)), longint'($signed(b)), er[0], eo[0]);
    ref_model(8,  1'b1, o, longint'($signed(a)), longint'($signed(b)), er[1], eo[1]);
    ref_model(16, 1'b0, o, longint'($signed(c)), longint'($signed(d)), er[2], eo[2]);
    exp_lat[0] = (o == 2'b10) ? 9 : 1;
    exp_lat[1] = exp_lat[0];
    exp_lat[2] = (o == 2'b10) ? 17 : 1;
    for (int i = 0; i < 3; i++) lat[i] = 0;

    op = o; a8 = a; b8 = b; a16 = c; b16 = d; in_valid = 1'b1;
    check("in_ready_idle", 32'({rdy2, rdy1, rdy0}), 32'h7);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      v = {vld2, vld1, vld0};
      for (int i = 0; i < 3; i++) if (v[i] && lat[i] == 0) lat[i] = k;
      if (&v) break;
      tick();
    end
    check("latency_w8",  32'(lat[0]), 32'(exp_lat[0]));
    check("latency_s8",  32'(lat[1]), 32'(exp_lat[1]));
    check("latency_w16", 32'(lat[2]), 32'(exp_lat[2]));

    // Backpressure: offer a different operation while the result is pending.
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a8 = ~a; a16 = ~c; op = 2'b00;
      tick();
      check("busy_in_ready", 32'({rdy2, rdy1, rdy0}), 32'h0);
      check("busy_out_valid", 32'({vld2, vld1, vld0}), 32'h7);
    end
    in_valid = 1'b0;

    check("result_w8",  32'(r0), er[0]);
    check("ovr_w8",     32'(o0), 32'(eo[0]));
    check("result_s8",  32'(r1), er[1]);
    check("ovr_s8",     32'(o1), 32'(eo[1]));
    check("result_w16", 32'(r2), er[2]);
    check("ovr_w16",    32'(o2), 32'(eo[2]));
    last_r[0] = 32'(r0); last_r[1] = 32'(r1); last_r[2] = 32'(r2);
    last_o[0] = o0;      last_o[1] = o1;      last_o[2] = o2;

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_out_valid", 32'({vld2, vld1, vld0}), 32'h0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    tick();
    tick();
    check("reset_in_ready",  32'({rdy2, rdy1, rdy0}), 32'h0);
    check("reset_out_valid", 32'({vld2, vld1, vld0}), 32'h0);
    check("reset_result",    32'(r0), 32'h0);
    check("reset_ovr",       32'(o0), 32'h0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 32'({rdy2, rdy1, rdy0}), 32'h7);

    run_txn(2'b00, 8'd100, 8'd50, 16'd100, 16'd50, 0);
    check("add_100_50_wrap", last_r[0], 32'h96);
    check("add_100_50_ovr",  32'(last_o[0]), 32'h1);
    check("add_100_50_sat",  last_r[1], 32'h7F);

    run_txn(2'b01, 8'h80, 8'h01, 16'h8000, 16'h0001, 0);
    check("sub_min_1_wrap", last_r[0], 32'h7F);
    check("sub_min_1_sat",  last_r[1], 32'h80);
    check("sub_min_1_ovr",  32'(last_o[1]), 32'h1);
    run_txn(2'b01, 8'd5, 8'd7, 16'd5, 16'd7, 0);
    check("sub_5_7", last_r[0], 32'hFE);
    check("sub_5_7_ovr", 32'(last_o[0]), 32'h0);

    run_txn(2'b10, 8'd7, 8'hF7, 16'd181, 16'd181, 0);
    check("mul_7_m9", last_r[0], 32'hC1);
    check("mul_7_m9_ovr", 32'(last_o[0]), 32'h0);
    check("mul16_181sq", last_r[2], 32'h7FF9);
    check("mul16_181sq_ovr", 32'(last_o[2]), 32'h0);
    run_txn(2'b10, 8'hF4, 8'd11, 16'hFFF4, 16'd11, 0);
    check("mul_m12_11_wrap", last_r[0], 32'h7C);
    check("mul_m12_11_ovr",  32'(last_o[0]), 32'h1);
    check("mul_m12_11_sat",  last_r[1], 32'h80);

    run_txn(2'b00, 8'd3, 8'd4, 16'd3, 16'd4, 5);

    // Reset lands on the third multiply iteration edge.
    op = 2'b10; a8 = 8'd7; b8 = 8'hF7; a16 = 16'd300; b16 = 16'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midmul_reset_in_ready",  32'({rdy2, rdy1, rdy0}), 32'h7);
    check("midmul_reset_out_valid", 32'({vld2, vld1, vld0}), 32'h0);
    check("midmul_reset_result",    32'(r0), 32'h0);
    check("midmul_reset_ovr",       32'(o0), 32'h0);
    run_txn(2'b10, 8'h80, 8'hFF, 16'h8000, 16'hFFFF, 0);
    check("mul_min_m1_ovr", 32'(last_o[0]), 32'h1);
    check("mul_min_m1_sat", last_r[1], 32'h7F);

    run_txn(2'b11, 8'd1, 8'd2, 16'd1, 16'd2, 0);
    check("illegal_result", last_r[0], 32'h0);
    check("illegal_ovr",    32'(last_o[0]), 32'h1);

    for (int t = 0; t < 40; t++) begin
      run_txn(2'($urandom_range(0, 3)), pick8(), pick8(), pick16(), pick16(),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
